// File: rtl/victim_pkg.sv
// Shared types for the victim (write-back) buffer: entry layout, drain FSM states and
// line geometry.
package victim_pkg;

  localparam int LINE_OFFSET_BITS = 4;
  localparam int VB_WIDTH         = 128;
  localparam int VB_ADDR_WIDTH    = 16;
  localparam int VB_TAG_WIDTH     = VB_ADDR_WIDTH - LINE_OFFSET_BITS;

  typedef struct packed {
    logic [VB_TAG_WIDTH-1:0] tag;
    logic [VB_WIDTH-1:0]     data;
  } entry_t;

  localparam int ENTRY_BITS = $bits(entry_t);

  typedef enum logic {
    IDLE,
    WRITE
  } drain_state_t;

endpackage

// File: rtl/victim_store.sv
// DEPTH-entry register file for the victim buffer: one write port, a head read port, and
// flattened entry/valid vectors for the forwarding compare.
module victim_store
  import victim_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        we,
  input  logic [PTR_W-1:0]            waddr,
  input  entry_t                      wentry,
  input  logic [PTR_W-1:0]            head,
  input  logic [PTR_W:0]              count,
  output entry_t                      head_entry,
  output logic [DEPTH*ENTRY_BITS-1:0] entries_flat,
  output logic [DEPTH-1:0]            valid
);

  entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wentry;
  end

  assign head_entry = mem[head];

  // A slot is live when its distance from head (modulo DEPTH) is below the fill count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    assign entries_flat[i*ENTRY_BITS +: ENTRY_BITS] = mem[i];
    assign valid[i] = ({1'b0, PTR_W'(i) - head} < count);
  end

endmodule

// File: rtl/victim_buffer.sv
// Write-back victim buffer: FIFO of evicted lines drained oldest-first to pmem.
// Optional miss-address forwarding is enabled by defining VICTIM_FWD_EN.
module victim_buffer
  import victim_pkg::*;
#(
  parameter int WIDTH      = VB_WIDTH,
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = VB_ADDR_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ADDR_WIDTH-1:0]  in_addr,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   pmem_write,
  output logic [ADDR_WIDTH-1:0]  pmem_address,
  output logic [WIDTH-1:0]       pmem_wdata,
  input  logic                   pmem_resp,
  input  logic [ADDR_WIDTH-1:0]  lookup_addr,
  output logic                   lookup_hit,
  output logic [WIDTH-1:0]       lookup_data,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  drain_state_t                state;
  logic [PTR_W-1:0]            head;
  logic [PTR_W-1:0]            tail;
  logic                        push;
  logic                        pop;
  entry_t                      in_entry;
  entry_t                      head_entry;
  logic [DEPTH*ENTRY_BITS-1:0] entries_flat;
  logic [DEPTH-1:0]            valid;
  logic                        unused_bits;

  assign in_ready = (count != CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign push     = in_valid && in_ready;
  assign pop      = (state == WRITE) && pmem_resp;
  assign in_entry = '{tag: in_addr[ADDR_WIDTH-1:LINE_OFFSET_BITS], data: in_data};

  victim_store #(.DEPTH(DEPTH)) u_store (
    .clk          (clk),
    .we           (push),
    .waddr        (tail),
    .wentry       (in_entry),
    .head         (head),
    .count        (count),
    .head_entry   (head_entry),
    .entries_flat (entries_flat),
    .valid        (valid)
  );

  // Pointer/count bookkeeping and the drain FSM; the request fields are latched on entry
  // to WRITE so they stay stable until memory answers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      count        <= '0;
      head         <= '0;
      tail         <= '0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
      case (state)
        IDLE: begin
          if (count != '0) begin
            state        <= WRITE;
            pmem_write   <= 1'b1;
            pmem_address <= {head_entry.tag, LINE_OFFSET_BITS'(0)};
            pmem_wdata   <= head_entry.data;
          end
        end
        WRITE: begin
          if (pmem_resp) begin
            state        <= IDLE;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef VICTIM_FWD_EN
  logic [PTR_W-1:0] idx;
  entry_t           cand;

  // Walk live entries oldest to youngest so the youngest matching line ends up selected.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    idx         = '0;
    cand        = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx  = head + PTR_W'(k);
      cand = entries_flat[int'(idx)*ENTRY_BITS +: ENTRY_BITS];
      if (valid[idx] && (cand.tag == lookup_addr[ADDR_WIDTH-1:LINE_OFFSET_BITS])) begin
        lookup_hit  = 1'b1;
        lookup_data = cand.data;
      end
    end
  end

  assign unused_bits = ^{in_addr[LINE_OFFSET_BITS-1:0], lookup_addr[LINE_OFFSET_BITS-1:0]};
`else
  assign lookup_hit  = 1'b0;
  assign lookup_data = '0;
  assign unused_bits = ^{in_addr[LINE_OFFSET_BITS-1:0], lookup_addr, entries_flat, valid};
`endif

endmodule

// File: tb/tb_victim_buffer.sv
// Self-checking bench for victim_buffer: directed scenarios then random traffic, all
// compared against a queue-based reference model (honours VICTIM_FWD_EN).
module tb_victim_buffer;

  localparam int WIDTH = 128;
  localparam int DEPTH = 4;
  localparam int AW    = 16;
`ifdef VICTIM_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [AW-1:0]    in_addr;
  logic [WIDTH-1:0] in_data;
  logic             pmem_write;
  logic [AW-1:0]    pmem_address;
  logic [WIDTH-1:0] pmem_wdata;
  logic             pmem_resp;
  logic [AW-1:0]    lookup_addr;
  logic             lookup_hit;
  logic [WIDTH-1:0] lookup_data;
  logic             empty;
  logic [2:0]       count;

  always #5 clk = ~clk;

  victim_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_addr      (in_addr),
    .in_data      (in_data),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_resp    (pmem_resp),
    .lookup_addr  (lookup_addr),
    .lookup_hit   (lookup_hit),
    .lookup_data  (lookup_data),
    .empty        (empty),
    .count        (count)
  );

  typedef struct {
    logic [AW-5:0]    tag;
    logic [WIDTH-1:0] data;
  } line_t;

  line_t model_q[$];
  bit    model_busy;
  int    n_checks;
  int    n_fails;

  task automatic checkOutput(input string tag, input logic [WIDTH-1:0] act,
                             input logic [WIDTH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One cycle: drive inputs after the falling edge, compare outputs against the model,
  // then advance the model across the rising edge.
  task automatic applyStimulus(input bit rst, input bit iv, input logic [AW-1:0] addr,
                               input logic [WIDTH-1:0] data, input bit resp,
                               input logic [AW-1:0] laddr);
    line_t            e;
    bit               hit;
    logic [WIDTH-1:0] hdata;
    bit               do_pop;
    bit               do_push;
    bit               next_busy;
    reset       = rst;
    in_valid    = iv;
    in_addr     = addr;
    in_data     = data;
    pmem_resp   = resp;
    lookup_addr = laddr;
    #1;
    hit   = 1'b0;
    hdata = '0;
    if (FWD) begin
      for (int i = model_q.size() - 1; i >= 0; i--) begin
        if (model_q[i].tag == laddr[AW-1:4]) begin
          hit   = 1'b1;
          hdata = model_q[i].data;
          break;
        end
      end
    end
    checkOutput("pmem_write", pmem_write, model_busy);
    checkOutput("count", count, model_q.size());
    checkOutput("empty", empty, model_q.size() == 0);
    checkOutput("in_ready", in_ready, model_q.size() < DEPTH);
    checkOutput("lookup_hit", lookup_hit, hit);
    checkOutput("lookup_data", lookup_data, hdata);
    if (model_busy) begin
      checkOutput("pmem_address", pmem_address, {model_q[0].tag, 4'h0});
      checkOutput("pmem_wdata", pmem_wdata, model_q[0].data);
    end
    @(posedge clk);
    if (rst) begin
      model_q.delete();
      model_busy = 1'b0;
    end else begin
      do_pop    = model_busy && resp;
      do_push   = iv && (model_q.size() < DEPTH);
      next_busy = model_busy ? !resp : (model_q.size() != 0);
      if (do_pop) void'(model_q.pop_front());
      if (do_push) begin
        e.tag  = addr[AW-1:4];
        e.data = data;
        model_q.push_back(e);
      end
      model_busy = next_busy;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit resp);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, '0, resp, '0);
  endtask

  task automatic push_line(input logic [AW-1:0] addr, input bit resp);
    applyStimulus(1'b0, 1'b1, addr, rand_line(), resp, '0);
  endtask

  initial begin
    n_checks    = 0;
    n_fails     = 0;
    reset       = 1'b1;
    in_valid    = 1'b0;
    in_addr     = '0;
    in_data     = '0;
    pmem_resp   = 1'b0;
    lookup_addr = '0;
    model_busy  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_pmem_write", pmem_write, 1'b0);
    checkOutput("rst_in_ready", in_ready, 1'b1);
    checkOutput("rst_empty", empty, 1'b1);
    checkOutput("rst_count", count, 3'd0);
    checkOutput("rst_lookup_hit", lookup_hit, 1'b0);
    checkOutput("rst_pmem_address", pmem_address, 16'h0);
    checkOutput("rst_pmem_wdata", pmem_wdata, '0);

    // Single line: write appears two edges after the push, three-cycle memory latency.
    applyStimulus(1'b0, 1'b1, 16'h1230, rand_line(), 1'b0, '0);
    idle(1, 1'b0);
    checkOutput("t1_addr", pmem_address, 16'h1230);
    idle(3, 1'b0);
    idle(1, 1'b1);
    idle(2, 1'b0);

    // Fill to capacity, drop a fifth line, then drain with new pushes wrapping the pointers.
    for (int i = 0; i < 4; i++) push_line(AW'(16'h4000 + i * 16), 1'b0);
    push_line(16'h5550, 1'b0);
    checkOutput("t2_full_count", count, 3'd4);
    checkOutput("t2_full_ready", in_ready, 1'b0);
    idle(1, 1'b1);
    checkOutput("t2_ready_after_pop", in_ready, 1'b1);
    for (int i = 0; i < 12; i++) begin
      if (i % 3 == 0) push_line(AW'(16'h6000 + i * 16), 1'b1);
      else idle(1, (i % 2) == 0);
    end
    idle(16, 1'b1);

    // Push coinciding with a pop: accepted at count 2, rejected at count 4.
    push_line(16'h7000, 1'b0);
    push_line(16'h7010, 1'b0);
    push_line(16'h7020, 1'b1);
    checkOutput("t3_count_two", count, 3'd2);
    push_line(16'h7030, 1'b0);
    push_line(16'h7040, 1'b0);
    idle(1, 1'b0);
    push_line(16'h7050, 1'b1);
    checkOutput("t3_count_full_rejected", count, 3'd3);
    idle(16, 1'b1);

    // Reset during an outstanding write; a late response must be ignored.
    for (int i = 0; i < 3; i++) push_line(AW'(16'h8000 + i * 16), 1'b0);
    idle(1, 1'b0);
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, '0);
    checkOutput("t4_count", count, 3'd0);
    checkOutput("t4_pmem_write", pmem_write, 1'b0);
    checkOutput("t4_pmem_address", pmem_address, 16'h0);
    idle(1, 1'b1);
    idle(2, 1'b0);

    // Forwarding: same-tag lines, youngest wins; an unrelated address misses.
    push_line(16'h2000, 1'b0);
    push_line(16'h2008, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 16'h200C);
    checkOutput("t5_hit", lookup_hit, FWD);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 16'h3000);
    checkOutput("t5_miss", lookup_hit, 1'b0);
    idle(10, 1'b1);

    // Response while idle and empty.
    idle(1, 1'b1);
    checkOutput("t6_count", count, 3'd0);
    idle(2, 1'b0);

    // Random traffic over a small tag pool so lookups hit often.
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 99) == 0),
                    ($urandom_range(0, 99) < 55),
                    AW'({$urandom_range(0, 7), 4'($urandom)} | 16'h9000),
                    rand_line(),
                    ($urandom_range(0, 99) < 35),
                    AW'({$urandom_range(0, 7), 4'($urandom)} | 16'h9000));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fails);
    $finish;
  end

endmodule
